// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter; the owner keeps its grant until it releases.
// Define LOCK_TIMEOUT_EN to force a release after TIMEOUT grant cycles (pulses timeout).
module rr_arbiter8 #(
    parameter int NREQ    = 8,
    parameter int IDXW    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [IDXW-1:0] ptr, ptr_n, win, idx_n;
    logic [NREQ-1:0] gnt_n;
    logic rel, force_rel;
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end
    // Scan from the highest offset down so the closest requester at or after ptr wins.
    always_comb begin
        win = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[ptr + IDXW'(k)]) win = ptr + IDXW'(k);
    end
    assign rel = done || !req[gnt_idx];
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        ptr_n   = ptr;
        if (state == IDLE) begin
            if (|req) begin
                state_n = GRANT;
                gnt_n   = NREQ'(1) << win;
                idx_n   = win;
            end
        end else if (rel || force_rel) begin
            state_n = IDLE;
            gnt_n   = '0;
            ptr_n   = gnt_idx + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt     <= gnt_n;
            gnt_idx <= idx_n;
        end
    end
    assign gnt_valid = |gnt;
`ifdef LOCK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] hold_cnt;
    // A genuine release on the same edge takes precedence, so no timeout pulse then.
    assign force_rel = state == GRANT && hold_cnt == CW'(TIMEOUT - 1) && !rel;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= (state == GRANT && state_n == GRANT) ? hold_cnt + 1'b1 : '0;
            timeout  <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: vector table plus hand sequences, checked through an expected-output queue.
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'hFF;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid, timeout;
    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic [7:0] g;
        logic [2:0] i;
        logic       t;
        string      nm;
    } exp_t;
    typedef struct {
        logic [7:0] r;
        logic       d;
        logic [7:0] g;
        logic [2:0] i;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];

    rr_arbiter8 dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input exp_t e);
        n_chk++;
        if (gnt === e.g && gnt_idx === e.i && gnt_valid === (|e.g) && timeout === e.t)
            n_pass++;
        else
            $display("FAIL %s: gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
                     e.nm, gnt, gnt_idx, gnt_valid, timeout, e.g, e.i, |e.g, e.t);
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic cyc(input logic [7:0] r, input logic d, input logic [7:0] g,
                       input logic [2:0] i, input logic t, input string nm);
        exp_t e;
        @(negedge clk);
        req  = r;
        done = d;
        e = '{g, i, t, nm};
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmp(sb.pop_front());
    endtask

    initial begin
        vecs[0]  = '{8'hFF, 1'b0, 8'h01, 3'd0};
        vecs[1]  = '{8'hFF, 1'b1, 8'h00, 3'd0};
        vecs[2]  = '{8'h20, 1'b0, 8'h20, 3'd5};
        vecs[3]  = '{8'h20, 1'b0, 8'h20, 3'd5};
        vecs[4]  = '{8'hFF, 1'b0, 8'h20, 3'd5};
        vecs[5]  = '{8'h20, 1'b1, 8'h00, 3'd5};
        vecs[6]  = '{8'h61, 1'b1, 8'h40, 3'd6};
        vecs[7]  = '{8'h61, 1'b1, 8'h00, 3'd6};
        vecs[8]  = '{8'h81, 1'b0, 8'h80, 3'd7};
        vecs[9]  = '{8'h01, 1'b0, 8'h00, 3'd7};
        vecs[10] = '{8'h81, 1'b0, 8'h01, 3'd0};
        vecs[11] = '{8'h81, 1'b1, 8'h00, 3'd0};
        vecs[12] = '{8'h81, 1'b0, 8'h80, 3'd7};
        vecs[13] = '{8'h80, 1'b1, 8'h00, 3'd7};
        vecs[14] = '{8'h00, 1'b0, 8'h00, 3'd7};
        vecs[15] = '{8'h00, 1'b1, 8'h00, 3'd7};

        repeat (2) @(posedge clk);
        #1;
        cmp('{8'h00, 3'd0, 1'b0, "reset_hold"});
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 16; v++)
            cyc(vecs[v].r, vecs[v].d, vecs[v].g, vecs[v].i, 1'b0, $sformatf("vec%0d", v));

        for (int k = 0; k < 9; k++) begin
            cyc(8'hFF, 1'b0, 8'h01 << (k % 8), 3'(k % 8), 1'b0, $sformatf("fair_grant%0d", k));
            cyc(8'hFF, 1'b1, 8'h00, 3'(k % 8), 1'b0, $sformatf("fair_dead%0d", k));
        end

        cyc(8'h08, 1'b0, 8'h08, 3'd3, 1'b0, "pre_reset_grant");
        #2;
        rst = 1'b1;
        #1;
        cmp('{8'h00, 3'd0, 1'b0, "async_reset"});
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        cyc(8'h09, 1'b0, 8'h01, 3'd0, 1'b0, "ptr_after_reset");
        cyc(8'h09, 1'b1, 8'h00, 3'd0, 1'b0, "release_after_reset");

        cyc(8'h04, 1'b0, 8'h04, 3'd2, 1'b0, "lock_grant");
        for (int c = 1; c < 16; c++)
            cyc(8'h04, 1'b0, 8'h04, 3'd2, 1'b0, $sformatf("lock_hold%0d", c));
`ifdef LOCK_TIMEOUT_EN
        cyc(8'h04, 1'b0, 8'h00, 3'd2, 1'b1, "timeout_release");
        cyc(8'h04, 1'b0, 8'h04, 3'd2, 1'b0, "regrant_after_timeout");
`else
        cyc(8'h04, 1'b0, 8'h04, 3'd2, 1'b0, "no_timeout_hold");
        cyc(8'h04, 1'b0, 8'h04, 3'd2, 1'b0, "no_timeout_hold2");
`endif
        cyc(8'h04, 1'b1, 8'h00, 3'd2, 1'b0, "final_release");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
